// File: rtl/bus_sync_pkg.sv
// Shared definitions for the destination-domain synchronizer blocks.
// Holds the capture FSM state encoding and the default synchronizer depth.
package bus_sync_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StFirst  = 2'b01,
        StActive = 2'b10
    } sync_state_e;

    localparam int unsigned DefaultNumStages = 2;

endpackage

// File: rtl/bit_sync.sv
// Single-bit flop-chain synchronizer; stage 0 is the only flop that samples
// the asynchronous input.
module bit_sync
    import bus_sync_pkg::*;
#(
    parameter int unsigned NUM_STAGES = DefaultNumStages
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic sync_out
);

    logic [NUM_STAGES-1:0] r_stage;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stage <= '0;
        end else begin
            r_stage <= {r_stage[NUM_STAGES-2:0], async_in};
        end
    end

    assign sync_out = r_stage[NUM_STAGES-1];

endmodule

// File: rtl/bus_sync.sv
// Qualifier-based bus synchronizer: only bus_enable crosses through a flop chain;
// the bus is captured once on the synchronized rising edge of the qualifier.
module bus_sync
    import bus_sync_pkg::*;
#(
    parameter int unsigned NUM_STAGES = DefaultNumStages,
    parameter int unsigned BUS_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BUS_WIDTH-1:0] unsync_bus,
    input  logic                 bus_enable,
    input  logic                 err_clr,
    output logic [BUS_WIDTH-1:0] sync_bus,
    output logic                 enable_pulse,
    output logic                 short_err
);

    logic                 w_sync_en;
    logic                 w_load;
    logic                 w_err_set;
    sync_state_e          w_state_next;
    sync_state_e          r_state;
    logic [BUS_WIDTH-1:0] r_bus;
    logic                 r_pulse;
    logic                 r_err;

    bit_sync #(
        .NUM_STAGES (NUM_STAGES)
    ) u_en_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (bus_enable),
        .sync_out (w_sync_en)
    );

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_err_set    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_sync_en) begin
                    w_state_next = StFirst;
                    w_load       = 1'b1;
                end
            end
            StFirst: begin
                if (w_sync_en) begin
                    w_state_next = StActive;
                end else begin
                    // Qualifier vanished after one synchronized cycle: bus may not have settled.
                    w_state_next = StIdle;
                    w_err_set    = 1'b1;
                end
            end
            StActive: begin
                if (!w_sync_en) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
            r_bus   <= '0;
            r_pulse <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            // Registered copy of "state is FIRST" so the strobe lines up with the capture.
            r_pulse <= (w_state_next == StFirst);
            if (w_load) begin
                r_bus <= unsync_bus;
            end
            r_err   <= w_err_set | (r_err & ~err_clr);
        end
    end

    assign sync_bus     = r_bus;
    assign enable_pulse = r_pulse;
    assign short_err    = r_err;

endmodule

// File: tb/tb_bus_sync.sv
// Randomized bench for bus_sync: two instances (2-stage/8-bit and 3-stage/16-bit)
// compared each cycle against an edge-detect reference model plus directed checks.
module tb_bus_sync;

    localparam int NA = 2;
    localparam int NB = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] bus;
    logic        en;
    logic        clr;

    logic [7:0]  sb_a;
    logic        pa;
    logic        ea;
    logic [15:0] sb_b;
    logic        pb;
    logic        eb;

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_on = 1'b0;

    always #5 clk = ~clk;

    bus_sync #(
        .NUM_STAGES (NA),
        .BUS_WIDTH  (8)
    ) dut_a (
        .clk          (clk),
        .reset        (rst_n),
        .unsync_bus   (bus[7:0]),
        .bus_enable   (en),
        .err_clr      (clr),
        .sync_bus     (sb_a),
        .enable_pulse (pa),
        .short_err    (ea)
    );

    bus_sync #(
        .NUM_STAGES (NB),
        .BUS_WIDTH  (16)
    ) dut_b (
        .clk          (clk),
        .reset        (rst_n),
        .unsync_bus   (bus),
        .bus_enable   (en),
        .err_clr      (clr),
        .sync_bus     (sb_b),
        .enable_pulse (pb),
        .short_err    (eb)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: h holds the qualifier as sampled on each edge (bit 0 = newest).
    // The synchronized qualifier after edge t equals the sample of edge t-(N-1); a pulse
    // follows its rising edge, and an error follows a synchronized high lasting one cycle.
    function automatic logic tap(input logic [7:0] h, input logic e, input int i);
        logic [7:0] n;
        n = {h[6:0], e};
        return n[i];
    endfunction

    logic [7:0]  ha;
    logic [7:0]  hb;
    logic [7:0]  ma_bus;
    logic        ma_p;
    logic        ma_e;
    logic [15:0] mb_bus;
    logic        mb_p;
    logic        mb_e;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ha <= '0; ma_bus <= '0; ma_p <= 1'b0; ma_e <= 1'b0;
            hb <= '0; mb_bus <= '0; mb_p <= 1'b0; mb_e <= 1'b0;
        end else begin
            ha   <= {ha[6:0], en};
            hb   <= {hb[6:0], en};
            ma_p <= tap(ha, en, NA) & ~tap(ha, en, NA + 1);
            mb_p <= tap(hb, en, NB) & ~tap(hb, en, NB + 1);
            if (tap(ha, en, NA) & ~tap(ha, en, NA + 1)) ma_bus <= bus[7:0];
            if (tap(hb, en, NB) & ~tap(hb, en, NB + 1)) mb_bus <= bus;
            if (~tap(ha, en, NA) & tap(ha, en, NA + 1) & ~tap(ha, en, NA + 2)) ma_e <= 1'b1;
            else if (clr) ma_e <= 1'b0;
            if (~tap(hb, en, NB) & tap(hb, en, NB + 1) & ~tap(hb, en, NB + 2)) mb_e <= 1'b1;
            else if (clr) mb_e <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check_eq("cyc_pulse_a", 32'(pa),   32'(ma_p));
            check_eq("cyc_bus_a",   32'(sb_a), 32'(ma_bus));
            check_eq("cyc_err_a",   32'(ea),   32'(ma_e));
            check_eq("cyc_pulse_b", 32'(pb),   32'(mb_p));
            check_eq("cyc_bus_b",   32'(sb_b), 32'(mb_bus));
            check_eq("cyc_err_b",   32'(eb),   32'(mb_e));
        end
    end

    task automatic xfer(input logic [15:0] d, input int hi, input int lo,
                        inout int na, inout int nb);
        bus = d;
        en  = 1'b1;
        repeat (hi) begin
            @(negedge clk);
            na += int'(pa);
            nb += int'(pb);
        end
        en = 1'b0;
        repeat (lo) begin
            bus = 16'($urandom);
            @(negedge clk);
            na += int'(pa);
            nb += int'(pb);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int na;
        int nb;
        logic [15:0] d;

        rst_n = 1'b0;
        en    = 1'b0;
        bus   = '0;
        clr   = 1'b0;
        #1;
        check_eq("rst_bus_a",   32'(sb_a), 32'h0);
        check_eq("rst_pulse_a", 32'(pa),   32'h0);
        check_eq("rst_err_a",   32'(ea),   32'h0);
        check_eq("rst_bus_b",   32'(sb_b), 32'h0);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        chk_on = 1'b1;
        @(negedge clk);

        // Basic capture: pulse on the 3rd sampling edge for the 2-stage instance.
        bus = 16'h00A5;
        en  = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            check_eq($sformatf("basic_pulse_e%0d", i), 32'(pa), 32'(i == 3));
            if (i >= 3) check_eq($sformatf("basic_bus_e%0d", i), 32'(sb_a), 32'hA5);
        end
        en = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("basic_err", 32'(ea), 32'h0);

        // Parameter sweep: 3-stage/16-bit instance pulses on the 4th sampling edge.
        bus = 16'hBEEF;
        en  = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            check_eq($sformatf("sweep_pulse_e%0d", i), 32'(pb), 32'(i == 4));
        end
        check_eq("sweep_bus_b", 32'(sb_b), 32'hBEEF);
        en = 1'b0;
        repeat (6) @(negedge clk);

        // Back-to-back transfers.
        na = 0;
        nb = 0;
        xfer(16'h003C, 4, 4, na, nb);
        check_eq("b2b_bus_first", 32'(sb_a), 32'h3C);
        xfer(16'h00C3, 4, 4, na, nb);
        check_eq("b2b_pulses_a", 32'(na), 32'd2);
        check_eq("b2b_pulses_b", 32'(nb), 32'd2);
        check_eq("b2b_bus_second", 32'(sb_a), 32'hC3);

        // Short qualifier: one pulse, sticky error, then clear.
        na = 0;
        nb = 0;
        xfer(16'h0011, 1, 8, na, nb);
        check_eq("short_pulses_a", 32'(na), 32'd1);
        check_eq("short_err_a", 32'(ea), 32'h1);
        check_eq("short_err_b", 32'(eb), 32'h1);
        repeat (3) @(negedge clk);
        check_eq("short_err_held", 32'(ea), 32'h1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check_eq("clr_err_a", 32'(ea), 32'h0);
        check_eq("clr_err_b", 32'(eb), 32'h0);

        // Clear held through a new short-error set: set wins on that edge.
        bus = 16'h0022;
        en  = 1'b1;
        clr = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("setwins_err_a", 32'(ea), 32'h1);
        @(negedge clk);
        check_eq("setwins_cleared_a", 32'(ea), 32'h0);
        clr = 1'b0;
        repeat (6) @(negedge clk);

        // Reset while the 2-stage instance is in FIRST.
        bus = 16'h005A;
        en  = 1'b1;
        for (int i = 0; i < 10 && !pa; i++) @(negedge clk);
        check_eq("midrst_first_seen", 32'(pa), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_bus_a",   32'(sb_a), 32'h0);
        check_eq("midrst_pulse_a", 32'(pa),   32'h0);
        check_eq("midrst_err_a",   32'(ea),   32'h0);
        check_eq("midrst_bus_b",   32'(sb_b), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            check_eq($sformatf("release_pulse_e%0d", i), 32'(pa), 32'(i == 3));
        end
        check_eq("release_bus_a", 32'(sb_a), 32'h5A);
        en = 1'b0;
        repeat (6) @(negedge clk);

        // Random transfers honouring the source contract.
        na = 0;
        nb = 0;
        d  = '0;
        for (int t = 0; t < 20; t++) begin
            d = 16'($urandom);
            xfer(d, int'($urandom_range(4, 8)), int'($urandom_range(4, 8)), na, nb);
        end
        check_eq("rand_pulses_a", 32'(na), 32'd20);
        check_eq("rand_pulses_b", 32'(nb), 32'd20);

        // Bus churning with the qualifier low: nothing captured.
        na = 0;
        nb = 0;
        for (int i = 0; i < 20; i++) begin
            bus = 16'($urandom);
            @(negedge clk);
            na += int'(pa);
            nb += int'(pb);
        end
        check_eq("idle_pulses_a", 32'(na), 32'd0);
        check_eq("idle_pulses_b", 32'(nb), 32'd0);
        check_eq("idle_bus_a", 32'(sb_a), 32'(d[7:0]));
        check_eq("idle_bus_b", 32'(sb_b), 32'(d));

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_sync.md
# bus_sync

- Multi-bit data synchronizer for the destination clock domain, clocked by `clk` and reset by the synchronized reset output of the reset synchronizer.
- Moves `unsync_bus` across the domain boundary:
  - synchronizes only the single-bit `bus_enable` qualifier through a flop chain;
  - captures the bus on the qualifier's synchronized rising edge;
  - emits a one-cycle `enable_pulse` to downstream consumers (register file, UART TX, ALU).
- A sticky `short_err` flags qualifiers too brief to guarantee bus stability.

## Interface
- `NUM_STAGES`, default 2: synchronizer flops on `bus_enable`; legal range ≥2.
- `BUS_WIDTH`, default 8: data width.
- `clk  input  1`: destination clock.
- `reset  input  1`: asynchronous, active-low reset; asserts immediately, released synchronously (already synchronized upstream).
- `unsync_bus  input  BUS_WIDTH`: source-domain data, unsynchronized.
- `bus_enable  input  1`: source-domain qualifier, level; high while `unsync_bus` is valid.
- `err_clr  input  1`: synchronous clear of `short_err`.
- `sync_bus  output  BUS_WIDTH`: captured data; holds between captures.
- `enable_pulse  output  1`: one-cycle strobe, registered, coincident with the new `sync_bus`.
- `short_err  output  1`: sticky flag, registered.

## Operation
- **Sync chain:**
  - `stage[0] <= bus_enable`, `stage[i] <= stage[i-1]`.
  - `sync_en = stage[NUM_STAGES-1]`.
  - `unsync_bus` is never passed through the chain.
- **FSM states:** IDLE, FIRST, ACTIVE.
  - IDLE: `sync_en=1` → FIRST, load `sync_bus <= unsync_bus`; `sync_en=0` → stay.
  - FIRST: `sync_en=1` → ACTIVE; `sync_en=0` → IDLE and set `short_err`.
  - ACTIVE: `sync_en=1` → stay; `sync_en=0` → IDLE.
- **`enable_pulse`** is 1 exactly while state == FIRST. Driven from a register, never decoded combinationally from chain bits.
- **`sync_bus`:**
  - Loads only on the IDLE→FIRST transition.
  - Otherwise holds, including through ACTIVE, IDLE, and the error path.
- **`short_err`:**
  - Set on FIRST→IDLE.
  - Cleared by `err_clr` otherwise.
  - Set and clear in the same cycle → set wins.
  - Remains 1 until cleared or reset.
- **Source contract:**
  - `unsync_bus` is stable from before `bus_enable` rises until `bus_enable` falls.
  - `bus_enable` high time is ≥ `NUM_STAGES+1` destination cycles.
  - Low gap between qualifiers is ≥ `NUM_STAGES+1` destination cycles.
  - The block does not detect low-gap violations; a merged qualifier yields one pulse.

## Timing
- **Reset values:** all chain flops 0, state IDLE, `sync_bus` 0, `enable_pulse` 0, `short_err` 0, applied asynchronously on `reset=0`.
- **Latency:** `bus_enable` sampled high at edge k → `sync_en` high after edge k+NUM_STAGES−1 → `enable_pulse`=1 and `sync_bus` updated after edge k+NUM_STAGES. For `NUM_STAGES`=2, the pulse appears after the 3rd edge that samples the qualifier.
- **`enable_pulse` width:** exactly 1 cycle per qualifier, regardless of how long `bus_enable` stays high.
- **Falling edge:** deassertion produces no output event. State returns to IDLE `NUM_STAGES` edges after `bus_enable` is sampled low.
- **Reset mid-transfer:** everything clears immediately and any in-flight qualifier is discarded. If `bus_enable` is still high at reset release, it is treated as a new qualifier: pulse `NUM_STAGES`+1 edges after release.
- **Metastability:** `stage[0]` is the only flop sampling an asynchronous input.

## Structure
- **Shared package:**
  - state enum: IDLE=2'b00, FIRST=2'b01, ACTIVE=2'b10;
  - default `NUM_STAGES` constant.
  - The package is reused by other synchronizer blocks in the design.
- **Sub-module `bit_sync`:**
  - parameterized `NUM_STAGES`; ports `clk`, `reset`, `async_in`, `sync_out`;
  - instantiated once for `bus_enable`.
- **Top level:** FSM, capture register, and error flag.
- **Implementation size:** 120–200 RTL lines total.

## Test plan
- **Basic capture:** `bus_enable` high 6 cycles with `unsync_bus`=8'hA5 → `enable_pulse` single cycle 3 edges after the first sampling edge; `sync_bus`=8'hA5 in that cycle and held afterward; `short_err`=0.
- **Back-to-back transfers:** 8'h3C then 8'hC3, each with 4-cycle high and 4-cycle gap → exactly two pulses; `sync_bus` changes only at each pulse.
- **Short qualifier:** `bus_enable` high for 1 destination cycle → one pulse, `short_err`=1 and held.
  - Assert `err_clr` → `short_err`=0 next cycle.
  - `err_clr` in the same cycle as a new short-error set → stays 1.
- **Reset mid-transfer:** `reset` low while state=FIRST → all outputs 0 immediately.
  - Release with `bus_enable` held high and bus=8'h5A → one pulse 3 edges after release, `sync_bus`=8'h5A.
- **Parameter sweep:** `NUM_STAGES`=3, `BUS_WIDTH`=16, data 16'hBEEF → pulse 4 edges after the first sampling edge; `sync_bus`=16'hBEEF.
- **Unstable bus outside the window:** `unsync_bus` toggles randomly while `bus_enable`=0 → `sync_bus` holds and no pulse.
